// File: rtl/pico_div.sv
// rtl/pico_div.sv - multi-cycle restoring integer divider for the pico datapath
//
// Purpose: divides a_i by b_i in W+2 cycles (launch, W restoring steps, one
// fix-up/register stage) and presents quotient, remainder and ALU-style flags.
// Truncates toward zero; the remainder carries the dividend's sign.
//
// Optional feature: define DIV_SIGNED_EN to honour signed_i (two's-complement
// divide). Without it every division is unsigned and signed_i is ignored.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_ni    asynchronous active-low reset
//   start_i   launch request, sampled only while idle
//   signed_i  1 = signed divide (DIV_SIGNED_EN builds only), sampled with start_i
//   a_i, b_i  dividend / divisor, sampled with start_i
//   busy_o    high while a division is in progress (CALC and FIX)
//   done_o    one-cycle pulse; q_o/r_o/flags_o valid from this cycle
//   q_o, r_o  quotient / remainder, held until the next completion
//   flags_o   zero, negative, carry (inexact), overflow (div0 or -2^(W-1)/-1)

package pico;
  parameter int N = 8;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } flagsALU;
endpackage

module pico_div #(
  parameter int W  = pico::N,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          signed_i,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [W-1:0]  q_o,
  output logic [W-1:0]  r_o,
  output pico::flagsALU flags_o
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]  quo;
  logic [W-1:0]  rem;
  logic [W-1:0]  dvs;
  logic [W-1:0]  a_raw;
  logic          div0;
  logic          ovf;
  logic [CW-1:0] cnt;

  logic          accept;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic          ovf_ld;

  logic [W:0]    shifted;
  logic [W:0]    diff;
  logic          ge;
  logic          unused_diff_msb;

  logic [W-1:0]  q_fix;
  logic [W-1:0]  r_fix;
  pico::flagsALU f_fix;

  assign accept = (state == IDLE) && start_i;
  assign busy_o = (state != IDLE);

`ifdef DIV_SIGNED_EN
  logic sign_q;
  logic sign_r;
  logic a_neg;
  logic b_neg;

  // The unsigned magnitude of -2^(W-1) is 2^(W-1), which still fits in W bits
  // because the magnitudes are treated as unsigned from here on.
  assign a_neg  = signed_i & a_i[W-1];
  assign b_neg  = signed_i & b_i[W-1];
  assign a_mag  = a_neg ? -a_i : a_i;
  assign b_mag  = b_neg ? -b_i : b_i;
  assign ovf_ld = signed_i && (a_i == {1'b1, {(W-1){1'b0}}}) && (b_i == '1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (accept) begin
      sign_q <= a_neg ^ b_neg;
      sign_r <= a_neg;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = signed_i;
  assign a_mag         = a_i;
  assign b_mag         = b_i;
  assign ovf_ld        = 1'b0;
`endif

  // One restoring step: shift the next dividend bit into the partial
  // remainder and keep the trial subtraction when it does not borrow.
  assign shifted         = {rem, quo[W-1]};
  assign ge              = (shifted >= {1'b0, dvs});
  assign diff            = shifted - {1'b0, dvs};
  assign unused_diff_msb = diff[W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = CALC;
      CALC:    if (cnt == CW'(W - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      a_raw <= '0;
      div0  <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      quo   <= a_mag;
      rem   <= '0;
      dvs   <= b_mag;
      a_raw <= a_i;
      div0  <= (b_i == '0);
      ovf   <= ovf_ld;
      cnt   <= '0;
    end else if (state == CALC) begin
      quo <= {quo[W-2:0], ge};
      rem <= ge ? diff[W-1:0] : shifted[W-1:0];
      cnt <= cnt + 1'b1;
    end
  end

  // Sign restoration and override selection for the result stage.
  always_comb begin
`ifdef DIV_SIGNED_EN
    q_fix = sign_q ? -quo : quo;
    r_fix = sign_r ? -rem : rem;
`else
    q_fix = quo;
    r_fix = rem;
`endif
    if (div0) begin
      q_fix = '1;
      r_fix = a_raw;
    end else if (ovf) begin
      q_fix = a_raw;
      r_fix = '0;
    end
    f_fix.zero     = (q_fix == '0);
    f_fix.negative = q_fix[W-1];
    f_fix.carry    = (r_fix != '0);
    f_fix.overflow = div0 | ovf;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_o  <= 1'b0;
      q_o     <= '0;
      r_o     <= '0;
      flags_o <= '0;
    end else begin
      done_o <= (state == FIX);
      if (state == FIX) begin
        q_o     <= q_fix;
        r_o     <= r_fix;
        flags_o <= f_fix;
      end
    end
  end

endmodule

// File: tb/tb_pico_div.sv
// tb/tb_pico_div.sv - self-checking bench for pico_div (W = 8)
//
// Purpose: directed vectors with hand-computed results, an arithmetic
// reference model of the divider's externally visible behaviour, and a
// per-cycle compare of every DUT output against that model.

module tb_pico_div;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sgn = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  q;
  logic [W-1:0]  r;
  pico::flagsALU flags;
  logic [3:0]    fl;

  int vectors = 0;
  int miscompares = 0;

  assign fl = flags;

  always #5 clk = ~clk;

  pico_div dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .signed_i (sgn),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .done_o   (done),
    .q_o      (q),
    .r_o      (r),
    .flags_o  (flags)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of one division straight from the arithmetic rules:
  // returns {q, r, zero, negative, carry, overflow}.
  function automatic logic [19:0] model(input logic s_in, input logic [7:0] x, input logic [7:0] y);
    int ix, iy, iq, ir;
    logic [7:0] mq, mr;
    logic v, s;
`ifdef DIV_SIGNED_EN
    s = s_in;
`else
    s = s_in & 1'b0;
`endif
    v = 1'b0;
    if (y == 8'd0) begin
      mq = 8'hFF; mr = x; v = 1'b1;
    end else if (s && x == 8'h80 && y == 8'hFF) begin
      mq = 8'h80; mr = 8'h00; v = 1'b1;
    end else if (s) begin
      ix = int'($signed(x));
      iy = int'($signed(y));
      iq = ix / iy;
      ir = ix % iy;
      mq = iq[7:0];
      mr = ir[7:0];
    end else begin
      mq = x / y;
      mr = x % y;
    end
    return {mq, mr, (mq == 8'd0), mq[7], (mr != 8'd0), v};
  endfunction

  // Cycle-level view: a division occupies W+1 busy cycles after the start
  // edge, then the results appear together with a one-cycle done.
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [7:0]  m_q = '0;
  logic [7:0]  m_r = '0;
  logic [3:0]  m_fl = '0;
  logic [19:0] p_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_fl   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_q    <= p_res[19:12];
          m_r    <= p_res[11:4];
          m_fl   <= p_res[3:0];
        end
      end else if (start) begin
        p_res <= model(sgn, a, b);
        m_cnt <= W + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("q", {24'd0, q}, {24'd0, m_q});
    chk("r", {24'd0, r}, {24'd0, m_r});
    chk("flags", {28'd0, fl}, {28'd0, m_fl});
  end

  typedef struct {
    logic       s;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] eq;
    logic [7:0] er;
    logic [3:0] ef;
  } vec_t;

  vec_t vt[8];

  task automatic run_div(input logic s_in, input logic [7:0] x, input logic [7:0] y,
                         input bit pulse, output int lat);
    sgn   = s_in;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    sgn   = ~s_in;
    lat   = 1;
    while (lat <= 40) begin
      @(negedge clk);
      if (done) break;
      start = (pulse && lat == 4);
      lat++;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int dones;
    logic [19:0] mres;

    // flags order: {zero, negative, carry, overflow}
    vt[0] = '{1'b0, 8'd200, 8'd7,  8'd28,  8'd4,  4'b0010};
    vt[1] = '{1'b0, 8'h5A,  8'h00, 8'hFF,  8'h5A, 4'b0111};
    vt[2] = '{1'b0, 8'd0,   8'd9,  8'd0,   8'd0,  4'b1000};
    vt[3] = '{1'b0, 8'd255, 8'd1,  8'd255, 8'd0,  4'b0100};
    vt[4] = '{1'b0, 8'd100, 8'd10, 8'd10,  8'd0,  4'b0000};
`ifdef DIV_SIGNED_EN
    vt[5] = '{1'b1, 8'h9C,  8'd7,  8'hF2,  8'hFE, 4'b0110};
    vt[6] = '{1'b1, 8'h80,  8'hFF, 8'h80,  8'h00, 4'b0101};
    vt[7] = '{1'b1, 8'd100, 8'hF9, 8'hF2,  8'd2,  4'b0110};
`else
    vt[5] = '{1'b1, 8'h9C,  8'd7,  8'd22,  8'd2,  4'b0010};
    vt[6] = '{1'b1, 8'h80,  8'hFF, 8'h00,  8'h80, 4'b1010};
    vt[7] = '{1'b1, 8'd100, 8'hF9, 8'h00,  8'd100, 4'b1010};
`endif

    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_q", {24'd0, q}, 32'd0);
    chk("reset_flags", {28'd0, fl}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      mres = model(vt[i].s, vt[i].x, vt[i].y);
      chk($sformatf("model_vec%0d", i), {12'd0, mres}, {12'd0, vt[i].eq, vt[i].er, vt[i].ef});
      @(posedge clk);
      #2;
      run_div(vt[i].s, vt[i].x, vt[i].y, (i == 1), lat);
      chk($sformatf("latency_vec%0d", i), lat, 32'd10);
      chk($sformatf("q_vec%0d", i), {24'd0, q}, {24'd0, vt[i].eq});
      chk($sformatf("r_vec%0d", i), {24'd0, r}, {24'd0, vt[i].er});
      chk($sformatf("flags_vec%0d", i), {28'd0, fl}, {28'd0, vt[i].ef});
    end

    // start raised during the done cycle of the previous division
    run_div(vt[0].s, vt[0].x, vt[0].y, 1'b0, lat);
    chk("latency_on_done", lat, 32'd10);
    chk("q_on_done", {24'd0, q}, 32'd28);

    // start held high: one division per W+2 cycles
    @(posedge clk);
    #2;
    sgn   = 1'b0;
    a     = 8'd200;
    b     = 8'd7;
    start = 1'b1;
    dones = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #2;
      if (i == 30) start = 1'b0;
      @(negedge clk);
      if (done) dones++;
    end
    chk("held_start_dones", dones, 32'd3);

    // reset in the middle of CALC aborts the division
    @(posedge clk);
    #2;
    a     = 8'h5A;
    b     = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_q", {24'd0, q}, 32'd0);
    chk("midrst_r", {24'd0, r}, 32'd0);
    chk("midrst_flags", {28'd0, fl}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midrst_no_done", dones, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
